// File: rtl/orient_hist_ctrl.sv
// rtl/orient_hist_ctrl.sv - keypoint orientation histogram controller
module orient_hist_ctrl #(
    parameter int WIN    = 16,
    parameter int AW     = 10,
    parameter int HW     = 16,
    parameter int MD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          kp_valid,
    output logic          kp_ready,
    input  logic [AW-1:0] kp_x,
    input  logic [AW-1:0] kp_y,
    output logic          grad_rd_req,
    input  logic          grad_rd_gnt,
    output logic [AW-1:0] grad_x,
    output logic [AW-1:0] grad_y,
    input  logic          grad_vld,
    input  logic [7:0]    grad_dx,
    input  logic [7:0]    grad_dy,
    output logic [7:0]    md_dx,
    output logic [7:0]    md_dy,
    input  logic [7:0]    md_mag,
    input  logic [5:0]    md_dir,
    output logic          ori_valid,
    output logic [5:0]    ori_dir,
    output logic [HW-1:0] ori_peak
);
    localparam int NBINS = 36;
    localparam int NSAMP = WIN * WIN;
    localparam int CW    = $clog2(NSAMP + 1);
    localparam int PW    = $clog2(WIN);
    localparam int SW    = HW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ISSUE, S_DRAIN, S_SCAN, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     kpx_q, kpx_d, kpy_q, kpy_d;
    logic [PW-1:0]     col_q, col_d, row_q, row_d;
    logic [CW-1:0]     done_cnt_q, done_cnt_d;
    logic [MD_LAT-1:0] vld_sr_q, vld_sr_d;
    logic [HW-1:0]     bin_q [NBINS];
    logic [HW-1:0]     bin_d [NBINS];
    logic [5:0]        scan_idx_q, scan_idx_d;
    logic [HW-1:0]     max_q, max_d;
    logic [5:0]        max_idx_q, max_idx_d;
    logic [5:0]        ori_dir_q, ori_dir_d;
    logic [HW-1:0]     ori_peak_q, ori_peak_d;

    logic              smp_vld;
    logic              issue_last;
    logic              scan_last;
    logic              scan_hit;
    logic [HW-1:0]     scan_bin;
    logic [HW-1:0]     acc_sel;
    logic [SW-1:0]     acc_sum;
    logic [HW-1:0]     acc_val;

    assign md_dx = grad_dx;
    assign md_dy = grad_dy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (kp_valid) state_d = S_CLEAR;
            S_CLEAR: state_d = S_ISSUE;
            S_ISSUE: if (grad_rd_gnt && issue_last) state_d = S_DRAIN;
            S_DRAIN: if (done_cnt_d == CW'(NSAMP)) state_d = S_SCAN;
            S_SCAN:  if (scan_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        kp_ready    = (state_q == S_IDLE);
        grad_rd_req = (state_q == S_ISSUE);
        ori_valid   = (state_q == S_DONE);
        grad_x      = kpx_q - AW'(WIN / 2) + AW'(col_q);
        grad_y      = kpy_q - AW'(WIN / 2) + AW'(row_q);
        ori_dir     = ori_dir_q;
        ori_peak    = ori_peak_q;
    end

    // Only reads issued for the current keypoint may enter the sample pipe,
    // so stale data from an abandoned keypoint never reaches the bins.
    always_comb begin
        smp_vld    = vld_sr_q[MD_LAT-1];
        vld_sr_d   = MD_LAT'({vld_sr_q, grad_vld && (state_q == S_ISSUE || state_q == S_DRAIN)});
        done_cnt_d = (state_q == S_CLEAR) ? '0 : done_cnt_q + CW'(smp_vld);
        issue_last = (col_q == PW'(WIN - 1)) && (row_q == PW'(WIN - 1));
        kpx_d      = kpx_q;
        kpy_d      = kpy_q;
        col_d      = col_q;
        row_d      = row_q;
        if (state_q == S_IDLE && kp_valid) begin
            kpx_d = kp_x;
            kpy_d = kp_y;
        end
        if (state_q == S_CLEAR) begin
            col_d = '0;
            row_d = '0;
        end else if (state_q == S_ISSUE && grad_rd_gnt) begin
            if (col_q == PW'(WIN - 1)) begin
                col_d = '0;
                row_d = row_q + PW'(1);
            end else begin
                col_d = col_q + PW'(1);
            end
        end
    end

    // Saturating accumulate; out-of-range directions match no bin and are dropped.
    always_comb begin
        acc_sel = '0;
        for (int i = 0; i < NBINS; i++) begin
            if (md_dir == 6'(i)) acc_sel = bin_q[i];
        end
        acc_sum = {1'b0, acc_sel} + SW'(md_mag);
        acc_val = acc_sum[HW] ? {HW{1'b1}} : acc_sum[HW-1:0];
        for (int i = 0; i < NBINS; i++) begin
            bin_d[i] = bin_q[i];
            if (state_q == S_CLEAR) begin
                bin_d[i] = '0;
            end else if (smp_vld && md_dir == 6'(i)) begin
                bin_d[i] = acc_val;
            end
        end
    end

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        scan_bin = '0;
        for (int i = 0; i < NBINS; i++) begin
            if (scan_idx_q == 6'(i)) scan_bin = bin_q[i];
        end
        scan_hit   = (scan_bin > max_q);
        scan_last  = (scan_idx_q == 6'(NBINS - 1));
        scan_idx_d = scan_idx_q;
        max_d      = max_q;
        max_idx_d  = max_idx_q;
        ori_dir_d  = ori_dir_q;
        ori_peak_d = ori_peak_q;
        if (state_q == S_CLEAR) begin
            scan_idx_d = '0;
            max_d      = '0;
            max_idx_d  = '0;
        end else if (state_q == S_SCAN) begin
            scan_idx_d = scan_idx_q + 6'd1;
            if (scan_hit) begin
                max_d     = scan_bin;
                max_idx_d = scan_idx_q;
            end
            if (scan_last) begin
                ori_dir_d  = scan_hit ? scan_idx_q : max_idx_q;
                ori_peak_d = scan_hit ? scan_bin : max_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kpx_q      <= '0;
            kpy_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            done_cnt_q <= '0;
            vld_sr_q   <= '0;
            scan_idx_q <= '0;
            max_q      <= '0;
            max_idx_q  <= '0;
            ori_dir_q  <= '0;
            ori_peak_q <= '0;
            for (int i = 0; i < NBINS; i++) bin_q[i] <= '0;
        end else begin
            kpx_q      <= kpx_d;
            kpy_q      <= kpy_d;
            col_q      <= col_d;
            row_q      <= row_d;
            done_cnt_q <= done_cnt_d;
            vld_sr_q   <= vld_sr_d;
            scan_idx_q <= scan_idx_d;
            max_q      <= max_d;
            max_idx_q  <= max_idx_d;
            ori_dir_q  <= ori_dir_d;
            ori_peak_q <= ori_peak_d;
            for (int i = 0; i < NBINS; i++) bin_q[i] <= bin_d[i];
        end
    end

endmodule
